// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller.
package game_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t PLAY = 2'd2;
  localparam state_t OVER = 2'd3;

  localparam int DEF_SCORE_W = 4;
  typedef logic [DEF_SCORE_W-1:0] score_t;

  // Fill bits replicated to the counter width to form the all-0s / all-1s seeds.
  localparam logic SEED_FILL_ZERO = 1'b0;
  localparam logic SEED_FILL_ONE  = 1'b1;

endpackage

// File: rtl/game_round_controller_rise_detect.sv
// 1-bit rising-edge detector; the history bit samples every cycle.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) prev <= 1'b0;
    else      prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/game_round_controller.sv
// Round/score controller: re-arms multimodeCounter each round and tallies WINNER/LOSER rises.
module game_round_controller
  import game_pkg::*;
#(
  parameter int INPUT      = 4,
  parameter int SCORE_W    = 4,
  parameter int WIN_TARGET = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INPUT-1:0]   seedValue,
  input  logic               WINNER,
  input  logic               LOSER,
  output logic               INIT,
  output logic [INPUT-1:0]   initialValue,
  output logic [SCORE_W-1:0] winCount,
  output logic [SCORE_W-1:0] loseCount,
  output logic               GAMEOVER,
  output logic               GAMEWON
);

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] ONE    = SCORE_W'(1);

  state_t state;
  logic   win_rise;
  logic   lose_rise;
  logic   seed_ok;

  logic [SCORE_W-1:0] win_next;
  logic [SCORE_W-1:0] lose_next;

  rise_detect u_win_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (WINNER),
    .rise (win_rise)
  );

  rise_detect u_lose_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (LOSER),
    .rise (lose_rise)
  );

  // A terminal seed would make the counter score on its first cycle.
  assign seed_ok = (seedValue != {INPUT{SEED_FILL_ZERO}}) &&
                   (seedValue != {INPUT{SEED_FILL_ONE}});

  assign win_next  = winCount + ONE;
  assign lose_next = loseCount + ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      INIT         <= 1'b0;
      initialValue <= '0;
      winCount     <= '0;
      loseCount    <= '0;
      GAMEOVER     <= 1'b0;
      GAMEWON      <= 1'b0;
    end else begin
      INIT <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start && seed_ok) begin
            initialValue <= seedValue;
            winCount     <= '0;
            loseCount    <= '0;
            GAMEOVER     <= 1'b0;
            GAMEWON      <= 1'b0;
            INIT         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: state <= PLAY;
        PLAY: begin
          // Simultaneous rises cancel; only a single-sided rise scores.
          if (win_rise && !lose_rise) begin
            winCount <= win_next;
            if (win_next == TARGET) begin
              GAMEOVER <= 1'b1;
              GAMEWON  <= 1'b1;
              state    <= OVER;
            end else begin
              INIT  <= 1'b1;
              state <= LOAD;
            end
          end else if (lose_rise && !win_rise) begin
            loseCount <= lose_next;
            if (lose_next == TARGET) begin
              GAMEOVER <= 1'b1;
              GAMEWON  <= 1'b0;
              state    <= OVER;
            end else begin
              INIT  <= 1'b1;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed-vector bench for game_round_controller with hand-computed expectations.
module tb_game_round_controller;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] seedValue;
  logic       WINNER;
  logic       LOSER;
  logic       INIT;
  logic [3:0] initialValue;
  logic [3:0] winCount;
  logic [3:0] loseCount;
  logic       GAMEOVER;
  logic       GAMEWON;

  int vec_count = 0;
  int err_count = 0;

  game_round_controller #(.INPUT(4), .SCORE_W(4), .WIN_TARGET(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seedValue    (seedValue),
    .WINNER       (WINNER),
    .LOSER        (LOSER),
    .INIT         (INIT),
    .initialValue (initialValue),
    .winCount     (winCount),
    .loseCount    (loseCount),
    .GAMEOVER     (GAMEOVER),
    .GAMEWON      (GAMEWON)
  );

  always #5 clk = ~clk;

  // Observation vector: {INIT, initialValue, winCount, loseCount, GAMEOVER, GAMEWON, state}
  logic [16:0] obs;
  assign obs = {INIT, initialValue, winCount, loseCount, GAMEOVER, GAMEWON, dut.state};

  function automatic logic [16:0] pk(input logic i, input logic [3:0] iv, input logic [3:0] w,
                                     input logic [3:0] l, input logic go, input logic gw,
                                     input logic [1:0] st);
    return {i, iv, w, l, go, gw, st};
  endfunction

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; seedValue = 4'd0; WINNER = 1'b0; LOSER = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    do_reset();
    exp = pk(0, 4'd0, 4'd0, 4'd0, 0, 0, S_IDLE);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL reset_state: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_start();
    logic [16:0] exp;
    seedValue = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    exp = pk(1, 4'd6, 4'd0, 4'd0, 0, 0, S_LOAD);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL start_load: got %b expected %b", obs, exp);
    end
    step();
    exp = pk(0, 4'd6, 4'd0, 4'd0, 0, 0, S_PLAY);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL start_play: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_win_hold();
    logic [16:0] exp;
    WINNER = 1'b1;
    step();
    exp = pk(1, 4'd6, 4'd1, 4'd0, 0, 0, S_LOAD);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL win_edge: got %b expected %b", obs, exp);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      exp = pk(0, 4'd6, 4'd1, 4'd0, 0, 0, S_PLAY);
      vec_count++;
      if (obs !== exp) begin
        err_count++;
        $display("FAIL win_hold_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
    WINNER = 1'b0;
    step();
  endtask

  task automatic test_lose_to_over();
    logic [16:0] exp;
    for (int i = 1; i <= 3; i++) begin
      LOSER = 1'b1;
      step();
      if (i < 3) exp = pk(1, 4'd6, 4'd1, 4'(i), 0, 0, S_LOAD);
      else       exp = pk(0, 4'd6, 4'd1, 4'd3, 1, 0, S_OVER);
      vec_count++;
      if (obs !== exp) begin
        err_count++;
        $display("FAIL lose_rise%0d: got %b expected %b", i, obs, exp);
      end
      LOSER = 1'b0;
      step();
    end
    WINNER = 1'b1;
    step();
    WINNER = 1'b0;
    exp = pk(0, 4'd6, 4'd1, 4'd3, 1, 0, S_OVER);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL over_ignores_win: got %b expected %b", obs, exp);
    end
    seedValue = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL over_terminal_seed: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_terminal_seed();
    logic [16:0] exp;
    do_reset();
    exp = pk(0, 4'd0, 4'd0, 4'd0, 0, 0, S_IDLE);
    seedValue = 4'b1111; start = 1'b1;
    step();
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL seed_all1: got %b expected %b", obs, exp);
    end
    seedValue = 4'b0000;
    step();
    start = 1'b0;
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL seed_all0: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_both_rise();
    logic [16:0] exp;
    seedValue = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    step();
    WINNER = 1'b1; LOSER = 1'b1;
    step();
    exp = pk(0, 4'd6, 4'd0, 4'd0, 0, 0, S_PLAY);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL both_rise: got %b expected %b", obs, exp);
    end
    WINNER = 1'b0; LOSER = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_play();
    logic [16:0] exp;
    for (int i = 0; i < 2; i++) begin
      WINNER = 1'b1;
      step();
      WINNER = 1'b0;
      step();
    end
    exp = pk(0, 4'd6, 4'd2, 4'd0, 0, 0, S_PLAY);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL pre_reset_win2: got %b expected %b", obs, exp);
    end
    rst = 1'b0;
    step();
    exp = pk(0, 4'd0, 4'd0, 4'd0, 0, 0, S_IDLE);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL mid_play_reset: got %b expected %b", obs, exp);
    end
    seedValue = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL start_under_reset: got %b expected %b", obs, exp);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_win_game_and_restart();
    logic [16:0] exp;
    seedValue = 4'b1010; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) begin
      WINNER = 1'b1;
      step();
      WINNER = 1'b0;
      step();
    end
    exp = pk(0, 4'd10, 4'd3, 4'd0, 1, 1, S_OVER);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL win_game_over: got %b expected %b", obs, exp);
    end
    seedValue = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    exp = pk(1, 4'd3, 4'd0, 4'd0, 0, 0, S_LOAD);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL over_restart: got %b expected %b", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_win_hold();
    test_lose_to_over();
    test_terminal_seed();
    test_both_rise();
    test_reset_mid_play();
    test_win_game_and_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Round/score controller that sits directly downstream of multimodeCounter and also feeds it.
- Consumes the counter's WINNER/LOSER flags and keeps a win tally and a loss tally.
- Re-arms the counter for each new round by driving its INIT and initialValue inputs.
- Declares game over when either tally reaches a target.

Parameters:
- INPUT, 4, width of the counter value. Must match multimodeCounter INPUT.
- SCORE_W, 4, width of each tally register.
- WIN_TARGET, 3, tally value that ends the game. Legal range 1 to 2^SCORE_W-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset. 0 = reset, sampled on rising edge of clk.
- start  input  1  begin a game. Honoured only in IDLE or OVER.
- seedValue  input  INPUT  round start value, captured when start is honoured.
- WINNER  input  1  counter hit all 1s. Level signal from multimodeCounter.
- LOSER  input  1  counter hit all 0s. Level signal from multimodeCounter.
- INIT  output  1  load strobe to multimodeCounter.INIT.
- initialValue  output  INPUT  value driven to multimodeCounter.initialValue.
- winCount  output  SCORE_W  rounds won.
- loseCount  output  SCORE_W  rounds lost.
- GAMEOVER  output  1  game finished.
- GAMEWON  output  1  valid only while GAMEOVER=1. 1 = win tally reached target, 0 = loss tally reached target.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge), regardless of state:
  - state=IDLE.
  - INIT=0, initialValue=0, winCount=0, loseCount=0, GAMEOVER=0, GAMEWON=0.
  - Edge-detect history bits cleared.
  - Reset mid-game is honoured the same way; no partial state is retained.
- States: IDLE, LOAD, PLAY, OVER.
- IDLE:
  - Honour start=1 only if seedValue is neither all-0s nor all-1s. A terminal seed would score instantly.
  - When honoured: capture seedValue into initialValue, clear both tallies, go to LOAD.
  - A terminal seed leaves the block in IDLE with INIT=0.
- LOAD:
  - INIT=1 for exactly this one cycle.
  - Next state is always PLAY. start is ignored.
- PLAY:
  - INIT=0.
  - Rising-edge detect on WINNER and on LOSER: current level 1 and previous-cycle level 0.
  - History bits are sampled every cycle in every state.
  - WINNER rise only: winCount+1.
  - LOSER rise only: loseCount+1.
  - Both rising in the same cycle: neither counted, stay in PLAY.
  - After a counted event, if the updated tally equals WIN_TARGET: go to OVER, set GAMEOVER=1, set GAMEWON=(win side).
  - Otherwise go to LOAD, which re-arms the counter with the same initialValue.
  - start is ignored.
  - A level held high across many cycles counts once.
- OVER:
  - Tallies, GAMEOVER and GAMEWON hold. Further WINNER/LOSER activity is ignored.
  - A legal start clears GAMEOVER, GAMEWON and both tallies, captures the new seed, and goes to LOAD.
  - A terminal-seed start is ignored.
- Latency:
  - Edge detected in the cycle ending at edge N: tally updated and state set at edge N.
  - INIT is high during the cycle between edges N and N+1.
  - Start honoured at edge S: INIT high between S and S+1.
- Width rules:
  - Tallies never exceed WIN_TARGET, so no wrap is possible.
  - Increments are computed SCORE_W wide with no carry out.

Decomposition:
- Package game_pkg:
  - state enum typedef (IDLE, LOAD, PLAY, OVER), 2-bit.
  - score_t typedef parameterised by SCORE_W.
  - localparams for the all-0s/all-1s seed checks.
- Sub-module rise_detect: 1-bit rising-edge detector with synchronous active-low reset. Instantiated twice, for WINNER and LOSER.

Test Plan:
1. Reset, then start=1 with seedValue=4'b0110:
   - INIT=1 for exactly one cycle.
   - initialValue=4'd6.
   - Tallies 0, GAMEOVER=0.
2. In PLAY, WINNER 0→1 held 5 cycles:
   - winCount=1, counted once.
   - INIT re-pulses once the cycle after the edge.
   - loseCount unchanged.
3. WIN_TARGET=3, three separate LOSER rises, each followed by WINNER/LOSER low:
   - After the third: loseCount=3, GAMEOVER=1, GAMEWON=0, no INIT pulse.
   - A subsequent WINNER rise leaves winCount unchanged.
4. In IDLE, start=1 with seedValue=4'b1111, then 4'b0000:
   - State remains IDLE, INIT stays 0, initialValue stays 0.
5. In PLAY, WINNER and LOSER rise in the same cycle:
   - Both tallies unchanged, no INIT pulse, still PLAY.
6. rst=0 mid-PLAY with winCount=2:
   - At the next clk edge all outputs are 0 and the state is IDLE.
   - A start=1 pulse (seedValue=4'b0110) with rst held at 0 is ignored.
